vga_pattern_sequencer: RTL and testbench



---
 rtl/vga_pattern_sequencer.sv | 179 +++++++++++++++++
 tb/tb_vga_pattern_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_sequencer.sv
// Pixel source for the VGA driver: four test patterns, selected by a
// debounced push-button or an auto-advance frame timer. Pattern changes
// are applied only at a frame boundary, and each change starts a buzzer beep.
module vga_pattern_sequencer #(
    parameter int H_ACTIVE           = 640,
    parameter int V_ACTIVE           = 480,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter int BEEP_CYCLES        = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] cnt_h,
    input  logic [9:0] cnt_v,
    input  logic       key_n,
    input  logic       auto_en,
    output logic [5:0] vga_rgb,
    output logic [1:0] pattern_idx,
    output logic       fengmingqi
);

    localparam int FW = $clog2(FRAMES_PER_PATTERN) + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int BW = $clog2(BEEP_CYCLES) + 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_PATTERN - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BEEP_LD    = BW'(BEEP_CYCLES);

    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    // Bar edges (eighths of the line) and grey-ramp edges (quarters)
    localparam logic [9:0] B1 = 10'(H_ACTIVE * 1 / 8);
    localparam logic [9:0] B2 = 10'(H_ACTIVE * 2 / 8);
    localparam logic [9:0] B3 = 10'(H_ACTIVE * 3 / 8);
    localparam logic [9:0] B4 = 10'(H_ACTIVE * 4 / 8);
    localparam logic [9:0] B5 = 10'(H_ACTIVE * 5 / 8);
    localparam logic [9:0] B6 = 10'(H_ACTIVE * 6 / 8);
    localparam logic [9:0] B7 = 10'(H_ACTIVE * 7 / 8);
    localparam logic [9:0] G1 = 10'(H_ACTIVE * 1 / 4);
    localparam logic [9:0] G2 = 10'(H_ACTIVE * 2 / 4);
    localparam logic [9:0] G3 = 10'(H_ACTIVE * 3 / 4);

    typedef enum logic [1:0] {P_BARS, P_CHECK, P_GRAD, P_BORDER} pat_e;

    pat_e          state;
    logic          key_s1, key_s2, key_db;
    logic [DW-1:0] db_cnt;
    logic          adv_pending;
    logic          fb_cmp, fb_prev;
    logic [FW-1:0] frame_cnt;
    logic [BW-1:0] beep_cnt;
    logic [5:0]    rgb_nxt;
    logic [1:0]    grey;

    logic fb, key_fall, auto_exp, step;

    // Counters sit at the boundary position for two clocks; edge-detect
    // the registered compare so each frame yields a single pulse.
    assign fb       = fb_cmp & ~fb_prev;
    assign key_fall = (key_s2 != key_db) && (db_cnt == DB_LAST) && !key_s2;
    assign auto_exp = auto_en && (frame_cnt == FRAME_LAST);
    assign step     = fb && (adv_pending || auto_exp);

    assign pattern_idx = state;
    assign fengmingqi  = (beep_cnt != '0);

    // Frame-boundary compare and its delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_cmp  <= 1'b0;
            fb_prev <= 1'b0;
        end else begin
            fb_cmp  <= (cnt_v == V_ACT) && (cnt_h == 10'd0);
            fb_prev <= fb_cmp;
        end
    end

    // Key synchronizer and stability counter; debounced value follows only
    // after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_db <= 1'b1;
            db_cnt <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            if (key_s2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= key_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Pattern FSM, pending-advance flag, auto frame timer and beep timer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= P_BARS;
            adv_pending <= 1'b0;
            frame_cnt   <= '0;
            beep_cnt    <= '0;
        end else begin
            // A press landing on the fb cycle survives into the next frame
            if (key_fall)
                adv_pending <= 1'b1;
            else if (step)
                adv_pending <= 1'b0;

            if (step) begin
                unique case (state)
                    P_BARS:   state <= P_CHECK;
                    P_CHECK:  state <= P_GRAD;
                    P_GRAD:   state <= P_BORDER;
                    P_BORDER: state <= P_BARS;
                    default:  state <= P_BARS;
                endcase
            end

            if (!auto_en)
                frame_cnt <= '0;
            else if (fb)
                frame_cnt <= step ? '0 : frame_cnt + 1'b1;

            if (step)
                beep_cnt <= BEEP_LD;
            else if (beep_cnt != '0)
                beep_cnt <= beep_cnt - 1'b1;
        end
    end

    // Colour for the current pixel; black outside the active area
    always_comb begin
        rgb_nxt = 6'b000000;
        grey    = 2'd0;
        if (cnt_h < H_ACT && cnt_v < V_ACT) begin
            unique case (state)
                P_BARS: begin
                    if      (cnt_h < B1) rgb_nxt = 6'b111111;
                    else if (cnt_h < B2) rgb_nxt = 6'b111100;
                    else if (cnt_h < B3) rgb_nxt = 6'b001111;
                    else if (cnt_h < B4) rgb_nxt = 6'b001100;
                    else if (cnt_h < B5) rgb_nxt = 6'b110011;
                    else if (cnt_h < B6) rgb_nxt = 6'b110000;
                    else if (cnt_h < B7) rgb_nxt = 6'b000011;
                    else                 rgb_nxt = 6'b000000;
                end
                P_CHECK: rgb_nxt = {6{cnt_h[5] ^ cnt_v[5]}};
                P_GRAD: begin
                    if      (cnt_h < G1) grey = 2'd0;
                    else if (cnt_h < G2) grey = 2'd1;
                    else if (cnt_h < G3) grey = 2'd2;
                    else                 grey = 2'd3;
                    rgb_nxt = {grey, grey, grey};
                end
                P_BORDER: begin
                    if (cnt_h == 10'd0 || cnt_h == H_ACT - 10'd1 ||
                        cnt_v == 10'd0 || cnt_v == V_ACT - 10'd1)
                        rgb_nxt = 6'b111111;
                end
                default: rgb_nxt = 6'b000000;
            endcase
        end
    end

    // Registered colour output, one clock behind the counters
    always_ff @(posedge clk) begin
        if (!rst_n)
            vga_rgb <= 6'b000000;
        else
            vga_rgb <= rgb_nxt;
    end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer with shortened timers.
// The counter "driver" jumps straight to the pixels of interest and to the
// frame-boundary position, so a frame costs only a few clocks.
module tb_vga_pattern_sequencer;

    localparam int DEB  = 4;
    localparam int BEEP = 10;
    localparam int FPP  = 3;

    logic       clk = 1'b0;
    logic       rst_n, key_n, auto_en;
    logic [9:0] cnt_h, cnt_v;
    logic [5:0] vga_rgb;
    logic [1:0] pattern_idx;
    logic       fengmingqi;

    vga_pattern_sequencer #(
        .H_ACTIVE(640), .V_ACTIVE(480), .FRAMES_PER_PATTERN(FPP),
        .DEBOUNCE_CYCLES(DEB), .BEEP_CYCLES(BEEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cnt_h(cnt_h), .cnt_v(cnt_v),
        .key_n(key_n), .auto_en(auto_en), .vga_rgb(vga_rgb),
        .pattern_idx(pattern_idx), .fengmingqi(fengmingqi)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: frame-level view of the sequencer
    int m_pat     = 0;
    int m_frames  = 0;
    bit m_pending = 0;
    bit m_auto    = 0;

    // Beep monitor: length of each completed high run of the buzzer
    int beep_runs = 0;
    int beep_last = 0;
    int beep_cur  = 0;
    always @(negedge clk) begin
        if (fengmingqi === 1'b1) beep_cur++;
        else if (beep_cur != 0) begin
            beep_last = beep_cur;
            beep_runs++;
            beep_cur = 0;
        end
    end

    function automatic logic [5:0] ref_rgb(int p, int h, int v);
        if (h >= 640 || v >= 480) return 6'b000000;
        case (p)
            0: case (h / 80)
                   0: return 6'b111111;
                   1: return 6'b111100;
                   2: return 6'b001111;
                   3: return 6'b001100;
                   4: return 6'b110011;
                   5: return 6'b110000;
                   6: return 6'b000011;
                   default: return 6'b000000;
               endcase
            1: return (((h / 32) % 2) != ((v / 32) % 2)) ? 6'b111111 : 6'b000000;
            2: return 6'((h / 160) * 21);   // {g,g,g} == 21*g
            default: return (h == 0 || h == 639 || v == 0 || v == 479) ? 6'b111111 : 6'b000000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cnt(input int h, input int v);
        cnt_h = 10'(h);
        cnt_v = 10'(v);
    endtask

    // Present a pixel position and return the colour one clock later
    task automatic pix(input int h, input int v, output logic [5:0] got);
        set_cnt(h, v);
        tick();
        got = vga_rgb;
    endtask

    // Hold the key low for n clocks, then release long enough to settle
    task automatic press(input int n);
        key_n = 1'b0;
        repeat (n) tick();
        key_n = 1'b1;
        repeat (8) tick();
        if (n >= DEB) m_pending = 1;
    endtask

    // Counters park on the boundary position for two clocks, as the driver does
    task automatic frame_end();
        set_cnt(0, 480);
        tick();
        tick();
        set_cnt(5, 480);
        tick();
        if (m_pending || (m_auto && m_frames == FPP - 1)) begin
            m_pat     = (m_pat + 1) % 4;
            m_frames  = 0;
            m_pending = 0;
        end else if (m_auto) begin
            m_frames++;
        end
    endtask

    task automatic goto_pat(input int p);
        for (int i = 0; i < 4 && m_pat != p; i++) begin
            press(8);
            frame_end();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_n = 1'b1;
        set_cnt(85, 100);
        tick();
        tick();
        m_pat = 0; m_frames = 0; m_pending = 0;
    endtask

    task automatic test_reset();
        auto_en = 1'b0;
        m_auto  = 0;
        do_reset();
        n_vec++;
        if (vga_rgb !== 6'b000000) begin
            n_err++; $display("FAIL reset_rgb got=%b exp=000000", vga_rgb);
        end
        n_vec++;
        if (pattern_idx !== 2'd0) begin
            n_err++; $display("FAIL reset_pat got=%0d exp=0", pattern_idx);
        end
        n_vec++;
        if (fengmingqi !== 1'b0) begin
            n_err++; $display("FAIL reset_beep got=%b exp=0", fengmingqi);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bars();
        int          hs [5] = '{85, 639, 85, 0, 640};
        int          vs [5] = '{100, 100, 500, 0, 0};
        logic [5:0]  ex [5] = '{6'b111100, 6'b000000, 6'b000000, 6'b111111, 6'b000000};
        logic [5:0]  got;
        for (int i = 0; i < 5; i++) begin
            pix(hs[i], vs[i], got);
            n_vec++;
            if (got !== ex[i]) begin
                n_err++;
                $display("FAIL bars(%0d,%0d) got=%b exp=%b", hs[i], vs[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_key();
        int r;
        press(2);
        frame_end();
        n_vec++;
        if (pattern_idx !== 2'(m_pat) || m_pat != 0) begin
            n_err++; $display("FAIL key_glitch got=%0d exp=0", pattern_idx);
        end
        press(8);
        set_cnt(300, 200);
        repeat (3) tick();
        n_vec++;
        if (pattern_idx !== 2'd0) begin
            n_err++; $display("FAIL key_midframe got=%0d exp=0", pattern_idx);
        end
        r = beep_runs;
        frame_end();
        n_vec++;
        if (pattern_idx !== 2'(m_pat)) begin
            n_err++; $display("FAIL key_step got=%0d exp=%0d", pattern_idx, m_pat);
        end
        repeat (BEEP + 4) tick();
        n_vec++;
        if (beep_runs !== r + 1 || beep_last !== BEEP) begin
            n_err++; $display("FAIL key_beep runs=%0d len=%0d exp_runs=%0d exp_len=%0d",
                              beep_runs - r, beep_last, 1, BEEP);
        end
    endtask

    task automatic test_auto();
        int r, prev;
        do_reset();
        rst_n = 1'b1;
        auto_en = 1'b1;
        m_auto  = 1;
        tick();
        for (int f = 0; f < 4 * FPP; f++) begin
            r    = beep_runs;
            prev = m_pat;
            frame_end();
            n_vec++;
            if (pattern_idx !== 2'(m_pat)) begin
                n_err++; $display("FAIL auto_frame%0d got=%0d exp=%0d", f, pattern_idx, m_pat);
            end
            repeat (BEEP + 2) tick();
            if (prev != m_pat) begin
                n_vec++;
                if (beep_runs !== r + 1 || beep_last !== BEEP) begin
                    n_err++; $display("FAIL auto_beep%0d runs=%0d len=%0d exp_len=%0d",
                                      f, beep_runs - r, beep_last, BEEP);
                end
            end
        end
    endtask

    task automatic test_key_and_auto();
        goto_pat(1);
        repeat (FPP - 1 - m_frames) frame_end();  // next fb is the expiry frame
        press(8);
        frame_end();
        n_vec++;
        if (pattern_idx !== 2'(m_pat) || m_pat != 2) begin
            n_err++; $display("FAIL key_auto_single got=%0d exp=2", pattern_idx);
        end
        frame_end();
        n_vec++;
        if (pattern_idx !== 2'(m_pat)) begin
            n_err++; $display("FAIL key_auto_after got=%0d exp=%0d", pattern_idx, m_pat);
        end
        auto_en  = 1'b0;
        m_auto   = 0;
        m_frames = 0;
        tick();
    endtask

    task automatic test_patterns();
        int          sp [6] = '{1, 1, 2, 3, 3, 0};
        int          sh [6] = '{32, 32, 480, 0, 1, 700};
        int          sv [6] = '{0, 32, 10, 240, 240, 10};
        logic [5:0]  se [6] = '{6'b111111, 6'b000000, 6'b111111, 6'b111111, 6'b000000, 6'b000000};
        logic [5:0]  got;
        int          h, v;
        for (int i = 0; i < 6; i++) begin
            goto_pat(sp[i]);
            pix(sh[i], sv[i], got);
            n_vec++;
            if (got !== se[i]) begin
                n_err++;
                $display("FAIL pat%0d(%0d,%0d) got=%b exp=%b", sp[i], sh[i], sv[i], got, se[i]);
            end
        end
        for (int p = 0; p < 4; p++) begin
            goto_pat(p);
            for (int k = 0; k < 30; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    h = ($urandom_range(0, 1) != 0) ? 639 : int'($urandom_range(0, 1));
                    v = ($urandom_range(0, 1) != 0) ? 479 : int'($urandom_range(0, 1));
                end else begin
                    h = $urandom_range(0, 799);
                    v = $urandom_range(0, 524);
                end
                pix(h, v, got);
                n_vec++;
                if (got !== ref_rgb(m_pat, h, v)) begin
                    n_err++;
                    $display("FAIL rand_pat%0d(%0d,%0d) got=%b exp=%b", m_pat, h, v, got,
                             ref_rgb(m_pat, h, v));
                end
            end
        end
    endtask

    task automatic test_reset_mid_beep();
        goto_pat(1);
        press(8);
        frame_end();                 // to pattern 2, beep running
        key_n = 1'b0;                // debounced press lands mid-beep
        repeat (DEB + 2) tick();
        n_vec++;
        if (fengmingqi !== 1'b1 || pattern_idx !== 2'd2) begin
            n_err++; $display("FAIL pre_reset beep=%b pat=%0d exp beep=1 pat=2",
                              fengmingqi, pattern_idx);
        end
        do_reset();
        n_vec++;
        if (fengmingqi !== 1'b0 || pattern_idx !== 2'd0 || vga_rgb !== 6'b0) begin
            n_err++; $display("FAIL mid_reset beep=%b pat=%0d rgb=%b exp 0/0/0",
                              fengmingqi, pattern_idx, vga_rgb);
        end
        rst_n = 1'b1;
        repeat (4) tick();
        frame_end();
        n_vec++;
        if (pattern_idx !== 2'(m_pat) || m_pat != 0) begin
            n_err++; $display("FAIL pending_cleared got=%0d exp=0", pattern_idx);
        end
    endtask

    initial begin
        rst_n = 1'b0; key_n = 1'b1; auto_en = 1'b0;
        cnt_h = 10'd0; cnt_v = 10'd0;
        test_reset();
        test_bars();
        test_key();
        test_auto();
        test_key_and_auto();
        test_patterns();
        test_reset_mid_beep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
